control_cmd_dispatch: RTL and testbench
=======================================

Name: control_cmd_dispatch

Overview:
Command front-end that sits directly upstream of control_cmd_readrow. Consumes the deserialised byte stream (one byte per rx_valid pulse), decodes a one-byte opcode, then forwards the readrow payload (row selector plus pixel bytes) to control_cmd_readrow as registered data with enable pulses. Also handles a one-argument brightness command and guards every transaction with an inter-byte timeout and a done-handshake watchdog.

Parameters:
BYTES_PER_PIXEL, params_pkg::BYTES_PER_PIXEL, bytes per pixel in the readrow payload
PIXEL_WIDTH, params_pkg::PIXEL_WIDTH, columns per row
BRIGHTNESS_LEVELS, params_pkg::BRIGHTNESS_LEVELS, number of legal brightness codes (0..BRIGHTNESS_LEVELS-1)
OP_READROW, 8'h4C, opcode that starts a readrow transaction
OP_BRIGHTNESS, 8'h54, opcode that sets brightness; takes one argument byte
GAP_TIMEOUT, 4096, maximum clk cycles between payload bytes
DONE_TIMEOUT, 16, maximum clk cycles from last forwarded byte to readrow_done

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; sampled on rising clk
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
readrow_data  out  8  byte forwarded to control_cmd_readrow data_in
readrow_enable  out  1  one-cycle strobe for control_cmd_readrow enable
readrow_done  in  1  done pulse from control_cmd_readrow
readrow_abort  out  1  one-cycle pulse; downstream must return to row capture
brightness  out  $clog2(BRIGHTNESS_LEVELS)  current brightness code
busy  out  1  high whenever state is not IDLE
error  out  1  one-cycle pulse on any protocol fault

Behaviour:
- Reset (reset==0 at posedge): state IDLE; readrow_data=0, readrow_enable=0, readrow_abort=0, error=0, busy=0, brightness=BRIGHTNESS_LEVELS-1, counters cleared. Reset mid-transaction discards everything; no abort pulse is issued (downstream shares the reset).
- PAYLOAD = PIXEL_WIDTH*BYTES_PER_PIXEL+1 bytes (row selector first, then pixels in stream order); byte counter width $clog2(PAYLOAD+1).
- States: IDLE, FWD, WAIT_DONE, BRIGHT_ARG.
- IDLE: rx_valid with rx_data==OP_READROW -> FWD, byte counter=0, gap counter=0. rx_data==OP_BRIGHTNESS -> BRIGHT_ARG. Any other byte -> error pulse next cycle, remain IDLE. readrow_done in IDLE is ignored.
- FWD: each rx_valid -> next cycle readrow_data=rx_data and readrow_enable=1 (exactly 1 cycle latency); readrow_data holds until the next forwarded byte and returns to 0 on leaving WAIT_DONE. Byte counter increments; gap counter resets on every rx_valid. When the PAYLOAD-th byte is forwarded -> WAIT_DONE. Opcode values inside the payload are data, never decoded.
- FWD gap: gap counter reaching GAP_TIMEOUT with no rx_valid -> readrow_abort and error pulse, -> IDLE.
- readrow_done seen in FWD (early) -> error pulse, -> IDLE; no abort.
- WAIT_DONE: readrow_done within DONE_TIMEOUT cycles (counted from the cycle after the last enable) -> IDLE, no error. Timeout -> readrow_abort + error, -> IDLE. rx_valid arriving in WAIT_DONE is dropped and raises error; the state stays WAIT_DONE.
- BRIGHT_ARG: next rx_valid: if rx_data < BRIGHTNESS_LEVELS, brightness <= rx_data[width-1:0]; otherwise brightness is unchanged and error pulses. Either way -> IDLE. Gap timeout -> error, -> IDLE.
- error, readrow_enable, and readrow_abort are never high for more than one consecutive cycle. A readrow_done coincident with a timeout expiry counts as success.
- busy is a registered state != IDLE and rises the cycle after the opcode strobe.

Test Plan:
- Opcode 0x4C, then PAYLOAD bytes from row4 vector, readrow_done 3 cycles after last -> exactly PAYLOAD enable pulses, each readrow_data matching source byte 1 cycle later; busy falls after done; error never asserted.
- Two back-to-back readrow transactions with opcode 0x4C embedded as a payload byte -> second transaction is forwarded intact, embedded 0x4C is forwarded as data, total enables = 2*PAYLOAD.
- Payload stalled after 5 bytes for GAP_TIMEOUT cycles -> one readrow_abort + one error pulse, state IDLE, next 0x4C is accepted normally.
- Full payload with readrow_done withheld -> abort + error exactly DONE_TIMEOUT cycles after last enable.
- 0x54,0x02 -> brightness=2; 0x54,BRIGHTNESS_LEVELS -> error, brightness stays 2; unknown opcode 0x00 -> error, no enable.
- reset driven low during byte 10 of payload -> all outputs zero next cycle, brightness=BRIGHTNESS_LEVELS-1, no abort pulse.

Source files
------------

// File: rtl/control_cmd_dispatch.sv
// ============================================================================
// Module   : control_cmd_dispatch
// Brief    : Byte-stream command front-end for control_cmd_readrow; decodes
//            opcodes, forwards readrow payloads and sets brightness.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module control_cmd_dispatch #(
    parameter int          BYTES_PER_PIXEL   = 2,
    parameter int          PIXEL_WIDTH       = 8,
    parameter int          BRIGHTNESS_LEVELS = 4,
    parameter logic [7:0]  OP_READROW        = 8'h4C,
    parameter logic [7:0]  OP_BRIGHTNESS     = 8'h54,
    parameter int          GAP_TIMEOUT       = 4096,
    parameter int          DONE_TIMEOUT      = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [7:0]                           rx_data,
    input  logic                                 rx_valid,
    output logic [7:0]                           readrow_data,
    output logic                                 readrow_enable,
    input  logic                                 readrow_done,
    output logic                                 readrow_abort,
    output logic [$clog2(BRIGHTNESS_LEVELS)-1:0] brightness,
    output logic                                 busy,
    output logic                                 error
);

    localparam int c_PAYLOAD = PIXEL_WIDTH * BYTES_PER_PIXEL + 1;
    localparam int c_CNT_W   = $clog2(c_PAYLOAD + 1);
    localparam int c_GAP_W   = $clog2(GAP_TIMEOUT + 1);
    localparam int c_DONE_W  = $clog2(DONE_TIMEOUT + 1);
    localparam int c_BRT_W   = $clog2(BRIGHTNESS_LEVELS);

    localparam logic [c_CNT_W-1:0]  c_LAST_BYTE = c_CNT_W'(c_PAYLOAD - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [c_DONE_W-1:0] c_DONE_LAST = c_DONE_W'(DONE_TIMEOUT - 1);
    localparam logic [8:0]          c_LEVELS    = 9'(BRIGHTNESS_LEVELS);
    localparam logic [c_BRT_W-1:0]  c_BRT_RST   = c_BRT_W'(BRIGHTNESS_LEVELS - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FWD        = 2'd1,
        S_WAIT_DONE  = 2'd2,
        S_BRIGHT_ARG = 2'd3
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic [c_CNT_W-1:0]   r_byte_cnt,   w_byte_cnt_nxt;
    logic [c_GAP_W-1:0]   r_gap_cnt,    w_gap_cnt_nxt;
    logic [c_DONE_W-1:0]  r_done_cnt,   w_done_cnt_nxt;
    logic [7:0]           r_data,       w_data_nxt;
    logic [c_BRT_W-1:0]   r_brightness, w_brightness_nxt;
    logic                 r_enable,     w_enable_nxt;
    logic                 r_abort,      w_abort_nxt;
    logic                 r_error,      w_fault;
    logic                 r_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_done_cnt   <= '0;
            r_data       <= '0;
            r_brightness <= c_BRT_RST;
            r_enable     <= 1'b0;
            r_abort      <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_done_cnt   <= w_done_cnt_nxt;
            r_data       <= w_data_nxt;
            r_brightness <= w_brightness_nxt;
            r_enable     <= w_enable_nxt;
            r_abort      <= w_abort_nxt;
            // Keep error a single-cycle pulse even if faults arrive back to back
            r_error      <= w_fault & ~r_error;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_done_cnt_nxt   = r_done_cnt;
        w_data_nxt       = r_data;
        w_brightness_nxt = r_brightness;
        w_enable_nxt     = 1'b0;
        w_abort_nxt      = 1'b0;
        w_fault          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_READROW) begin
                        w_state_nxt    = S_FWD;
                        w_byte_cnt_nxt = '0;
                        w_gap_cnt_nxt  = '0;
                    end else if (rx_data == OP_BRIGHTNESS) begin
                        w_state_nxt    = S_BRIGHT_ARG;
                        w_gap_cnt_nxt  = '0;
                    end else begin
                        w_fault        = 1'b1;
                    end
                end
            end

            S_FWD: begin
                if (readrow_done) begin
                    // Downstream finished before it had the whole payload
                    w_fault     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = '0;
                end else if (rx_valid) begin
                    w_data_nxt     = rx_data;
                    w_enable_nxt   = 1'b1;
                    w_gap_cnt_nxt  = '0;
                    w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    if (r_byte_cnt == c_LAST_BYTE) begin
                        w_state_nxt    = S_WAIT_DONE;
                        w_done_cnt_nxt = '0;
                    end
                end else if (r_gap_cnt == c_GAP_LAST) begin
                    w_abort_nxt = 1'b1;
                    w_fault     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            S_WAIT_DONE: begin
                if (rx_valid) begin
                    w_fault = 1'b1;
                end
                // done takes priority so a done on the expiry cycle is a success
                if (readrow_done) begin
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = '0;
                end else if (r_done_cnt == c_DONE_LAST) begin
                    w_abort_nxt = 1'b1;
                    w_fault     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = '0;
                end else begin
                    w_done_cnt_nxt = r_done_cnt + 1'b1;
                end
            end

            S_BRIGHT_ARG: begin
                if (rx_valid) begin
                    if ({1'b0, rx_data} < c_LEVELS) begin
                        w_brightness_nxt = rx_data[c_BRT_W-1:0];
                    end else begin
                        w_fault = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt == c_GAP_LAST) begin
                    w_fault     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign readrow_data   = r_data;
    assign readrow_enable = r_enable;
    assign readrow_abort  = r_abort;
    assign brightness     = r_brightness;
    assign busy           = r_busy;
    assign error          = r_error;

endmodule

`default_nettype wire

// File: tb/tb_control_cmd_dispatch.sv
// ============================================================================
// Module   : tb_control_cmd_dispatch
// Brief    : Scoreboard bench for control_cmd_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_control_cmd_dispatch;

    localparam int BPP     = 2;
    localparam int PW      = 8;
    localparam int LEVELS  = 4;
    localparam int GAP_TO  = 4096;
    localparam int DONE_TO = 16;
    localparam int PAYLOAD = PW * BPP + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       readrow_done = 1'b0;
    logic [7:0] readrow_data;
    logic       readrow_enable;
    logic       readrow_abort;
    logic [1:0] brightness;
    logic       busy;
    logic       error;

    int total = 0;
    int bad = 0;
    int n_enable = 0;
    int n_abort = 0;
    int n_error = 0;
    logic [7:0] exp_q[$];

    control_cmd_dispatch #(
        .BYTES_PER_PIXEL(BPP), .PIXEL_WIDTH(PW), .BRIGHTNESS_LEVELS(LEVELS),
        .OP_READROW(8'h4C), .OP_BRIGHTNESS(8'h54),
        .GAP_TIMEOUT(GAP_TO), .DONE_TIMEOUT(DONE_TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .readrow_data(readrow_data), .readrow_enable(readrow_enable),
        .readrow_done(readrow_done), .readrow_abort(readrow_abort),
        .brightness(brightness), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every enable pops the oldest expected byte
    always @(negedge clk) begin
        if (reset) begin
            if (readrow_enable) begin
                n_enable++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_enable got=%02h expected=none", readrow_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (readrow_data !== e) begin
                        bad++;
                        $display("FAIL sb_data got=%02h expected=%02h", readrow_data, e);
                    end
                end
            end
            if (readrow_abort) n_abort++;
            if (error) n_error++;
        end
    end

    function automatic logic [7:0] row_byte(input int t, input int i);
        if (i == 0) return 8'd4;
        if (t == 1 && i == 3) return 8'h4C;
        if (t == 1 && i == 5) return 8'h54;
        return 8'((t * 32 + i * 7) & 8'hFF);
    endfunction

    // Drives one byte; returns at the negedge where its forwarded copy is visible
    task automatic send(input logic [7:0] b, input bit fwd);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (fwd) exp_q.push_back(b);
        @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if (readrow_enable !== fwd) begin
            bad++;
            $display("FAIL enable_latency byte=%02h got=%0b expected=%0b", b, readrow_enable, fwd);
        end
    endtask

    task automatic send_payload(input int t, input int nbytes);
        for (int i = 0; i < nbytes; i++) send(row_byte(t, i), 1'b1);
    endtask

    task automatic pulse_done(input int delay);
        repeat (delay) @(negedge clk);
        readrow_done = 1'b1;
        @(negedge clk);
        readrow_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_counts();
        n_enable = 0;
        n_abort  = 0;
        n_error  = 0;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({readrow_data, readrow_enable, readrow_abort, busy, error} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%03h expected=000",
                     {readrow_data, readrow_enable, readrow_abort, busy, error});
        end
        total++;
        if (brightness !== 2'(LEVELS - 1)) begin
            bad++;
            $display("FAIL reset_brightness got=%0d expected=%0d", brightness, LEVELS - 1);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_readrow();
        clear_counts();
        send(8'h4C, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_opcode got=%0b expected=1", busy);
        end
        send_payload(0, PAYLOAD);
        pulse_done(2);
        check_int("readrow_busy_after_done", int'(busy), 0);
        check_int("readrow_enables", n_enable, PAYLOAD);
        check_int("readrow_errors", n_error, 0);
        check_int("readrow_queue_left", exp_q.size(), 0);
        check_int("readrow_data_cleared", int'(readrow_data), 0);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send(8'h4C, 1'b0);
        send_payload(1, PAYLOAD);
        pulse_done(1);
        send(8'h4C, 1'b0);
        send_payload(2, PAYLOAD);
        pulse_done(1);
        check_int("b2b_enables", n_enable, 2 * PAYLOAD);
        check_int("b2b_errors", n_error, 0);
        check_int("b2b_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_gap_timeout();
        int cnt;
        clear_counts();
        send(8'h4C, 1'b0);
        send_payload(3, 5);
        cnt = 0;
        while (!readrow_abort && cnt < GAP_TO + 50) begin
            @(negedge clk);
            cnt++;
        end
        check_int("gap_abort_cycles", cnt, GAP_TO);
        @(negedge clk);
        check_int("gap_abort_pulses", n_abort, 1);
        check_int("gap_error_pulses", n_error, 1);
        check_int("gap_busy", int'(busy), 0);
        clear_counts();
        send(8'h4C, 1'b0);
        send_payload(4, PAYLOAD);
        pulse_done(1);
        check_int("gap_recover_enables", n_enable, PAYLOAD);
        check_int("gap_recover_errors", n_error, 0);
    endtask

    task automatic test_done_timeout();
        int cnt;
        clear_counts();
        send(8'h4C, 1'b0);
        send_payload(5, PAYLOAD);
        cnt = 0;
        while (!readrow_abort && cnt < DONE_TO + 20) begin
            @(negedge clk);
            cnt++;
        end
        check_int("done_abort_cycles", cnt, DONE_TO);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL done_error_with_abort got=%0b expected=1", error);
        end
        @(negedge clk);
        check_int("done_abort_pulses", n_abort, 1);
        check_int("done_error_pulses", n_error, 1);
        check_int("done_busy", int'(busy), 0);
        check_int("done_data_cleared", int'(readrow_data), 0);
    endtask

    task automatic test_brightness();
        clear_counts();
        send(8'h54, 1'b0);
        send(8'h02, 1'b0);
        check_int("bright_set", int'(brightness), 2);
        send(8'h54, 1'b0);
        send(8'(LEVELS), 1'b0);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL bright_range_error got=%0b expected=1", error);
        end
        check_int("bright_kept", int'(brightness), 2);
        send(8'h00, 1'b0);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL unknown_opcode_error got=%0b expected=1", error);
        end
        @(negedge clk);
        check_int("bright_error_pulses", n_error, 2);
        check_int("bright_no_enable", n_enable, 0);
        check_int("bright_busy", int'(busy), 0);
    endtask

    task automatic test_reset_mid();
        clear_counts();
        send(8'h4C, 1'b0);
        send_payload(6, 9);
        @(negedge clk);
        rx_data  = row_byte(6, 9);
        rx_valid = 1'b1;
        reset    = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if ({readrow_data, readrow_enable, readrow_abort, busy, error} !== 12'h000) begin
            bad++;
            $display("FAIL midreset_outputs got=%03h expected=000",
                     {readrow_data, readrow_enable, readrow_abort, busy, error});
        end
        check_int("midreset_brightness", int'(brightness), LEVELS - 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (DONE_TO + 4) @(negedge clk);
        check_int("midreset_no_abort", n_abort, 0);
        check_int("midreset_enables", n_enable, 9);
        check_int("midreset_queue_left", exp_q.size(), 0);
    endtask

    initial begin
        test_reset();
        test_readrow();
        test_back_to_back();
        test_gap_timeout();
        test_done_timeout();
        test_brightness();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
